id_stage: RTL
=============

// Module: id_stage
// PURPOSE
// - Instruction Decode stage. Sits directly downstream of the fetch stage and consumes if2id_valid/pc/instruction.
// - Decodes RV32I, reads the internal 32x32 register file and detects load-use hazards.
// - Registers the id2ex_* bundle that feeds EX.
// - The register file write port is driven from WB.
// PARAMETERS
// - XLEN       32  data/PC width
// - REG_AW      5  register address width
// - ALUOP_W     4  ALU opcode width (encodings in shared package)
// PORTS
// - clk              in   1      clock
// - rst              in   1      reset, synchronous, active-high
// - id_flush         in   1      kill instruction in ID (taken branch in EX)
// - if2id_valid      in   1      fetch output valid
// - if2id_pc         in   XLEN   PC of fetched instruction
// - if2id_instruction in  32     fetched instruction
// - ex_mem_read      in   1      instruction in EX is a load
// - ex_rd_addr       in   REG_AW rd of instruction in EX
// - wb_rd_wen        in   1      WB register write enable
// - wb_rd_addr       in   REG_AW WB destination
// - wb_rd_data       in   XLEN   WB write data
// - load_use_stall   out  1      hold IF/ID; ID inserts bubble
// - id2ex_valid      out  1      bundle valid
// - id2ex_pc         out  XLEN
// - id2ex_rs1_data   out  XLEN
// - id2ex_rs2_data   out  XLEN
// - id2ex_rs1_addr   out  REG_AW  (for EX forwarding)
// - id2ex_rs2_addr   out  REG_AW
// - id2ex_imm        out  XLEN   sign-extended immediate (I/S/B/U/J)
// - id2ex_rd_addr    out  REG_AW
// - id2ex_rd_wen     out  1      forced 0 when rd==x0
// - id2ex_alu_op     out  ALUOP_W
// - id2ex_alu_src_imm out 1      operand2 = imm
// - id2ex_mem_read   out  1
// - id2ex_mem_write  out  1
// - id2ex_mem_size   out  3      funct3 of load/store
// - id2ex_branch     out  1
// - id2ex_jump       out  1      JAL/JALR
// - id2ex_illegal    out  1      undecodable opcode/funct
// BEHAVIOUR
// - Reset: every id2ex_* output is 0 and the regfile is cleared to 0.
// - Latency: 1 clk from if2id_* to id2ex_*. Regfile read is combinational with WB write-through bypass (wb_rd_addr==rs && wb_rd_wen && rs!=0 -> wb_rd_data).
// - x0 reads 0. Writes to x0 are ignored.
// - Hazard: load_use_stall = if2id_valid & ex_mem_read & ex_rd_addr!=0 & (ex_rd_addr==rs1 used | ex_rd_addr==rs2 used).
//   - Used-ness comes from the format: U/J have no rs, I has rs1 only.
// - Update priority each clk:
//   - rst: clear.
//   - id_flush: id2ex_valid<=0, even when a stall is pending.
//   - load_use_stall: id2ex_valid<=0 (bubble); the data fields may hold.
//   - otherwise: id2ex_valid<=if2id_valid and all fields are loaded.
// - When id2ex_valid==0, the control bits id2ex_rd_wen/mem_read/mem_write/branch/jump are also 0.
// - Illegal instruction: id2ex_illegal=1 with all side-effect controls at 0; valid still propagates.
// - Immediates:
//   - I = inst[31:20]
//   - S = {inst[31:25],inst[11:7]}
//   - B = {inst[31],inst[7],inst[30:25],inst[11:8],0}
//   - U = inst[31:12]<<12
//   - J = {inst[31],inst[19:12],inst[20],inst[30:21],0}
//   - All are sign-extended from inst[31].
// - Simultaneous WB write and ID read of the same register returns the new value.
// CONFIGURATION
// - VERIRISCV_RV32M_EN defined: OP with funct7=0000001 decodes to MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU ALU ops; ALUOP_W must be >=5.
// - Undefined: those encodings raise id2ex_illegal.
// STRUCTURE
// - Shared package/header veririscv_core.vh holds: opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM), ALU op encodings, immediate-type enum.
// - Sub-module regfile: 2 async read ports, 1 sync write port, x0 zero, bypass logic.
// - Decode is a combinational block inside id_stage.
// TESTING
// - ADDI x1,x0,5 (0x00500093), valid=1 -> next clk: id2ex_valid=1, imm=5, rd=1, rd_wen=1, alu_src_imm=1, alu_op=ADD.
// - WB write x3=0xDEADBEEF in the same clk as ID decodes ADD x4,x3,x3 -> id2ex_rs1_data = id2ex_rs2_data = 0xDEADBEEF.
// - EX holds LW x5 (ex_mem_read=1, ex_rd_addr=5); ID holds ADD x6,x5,x1 -> load_use_stall=1, next id2ex_valid=0. Same with ex_rd_addr=0 -> no stall.
// - id_flush=1 together with valid BEQ -> next id2ex_valid=0, branch=0.
// - BEQ with negative offset -8 (0xFE000CE3) -> id2ex_imm=0xFFFFFFF8, branch=1. JAL x1,+2048 -> imm=0x00000800, jump=1.
// - Instruction 0x02208033 (MUL) -> alu_op=MUL with the macro defined, illegal=1 without it. rst mid-stream -> all id2ex_* =0 next clk.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID stage: widths, RV32I opcodes, ALU op codes, immediate kinds.
// VERIRISCV_RV32M_EN widens the ALU op field and adds the M-extension ops.
package id_stage_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
`ifdef VERIRISCV_RV32M_EN
  localparam int ALUOP_W = 5;
`else
  localparam int ALUOP_W = 4;
`endif

  typedef logic [ALUOP_W-1:0] alu_op_t;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  localparam alu_op_t ALU_ADD    = alu_op_t'(0);
  localparam alu_op_t ALU_SUB    = alu_op_t'(1);
  localparam alu_op_t ALU_SLL    = alu_op_t'(2);
  localparam alu_op_t ALU_SLT    = alu_op_t'(3);
  localparam alu_op_t ALU_SLTU   = alu_op_t'(4);
  localparam alu_op_t ALU_XOR    = alu_op_t'(5);
  localparam alu_op_t ALU_SRL    = alu_op_t'(6);
  localparam alu_op_t ALU_SRA    = alu_op_t'(7);
  localparam alu_op_t ALU_OR     = alu_op_t'(8);
  localparam alu_op_t ALU_AND    = alu_op_t'(9);
  localparam alu_op_t ALU_PASS_B = alu_op_t'(10);  // LUI: result is the immediate
  localparam alu_op_t ALU_ADD_PC = alu_op_t'(11);  // AUIPC: pc + immediate
`ifdef VERIRISCV_RV32M_EN
  localparam alu_op_t ALU_MUL    = alu_op_t'(16);
  localparam alu_op_t ALU_MULH   = alu_op_t'(17);
  localparam alu_op_t ALU_MULHSU = alu_op_t'(18);
  localparam alu_op_t ALU_MULHU  = alu_op_t'(19);
  localparam alu_op_t ALU_DIV    = alu_op_t'(20);
  localparam alu_op_t ALU_DIVU   = alu_op_t'(21);
  localparam alu_op_t ALU_REM    = alu_op_t'(22);
  localparam alu_op_t ALU_REMU   = alu_op_t'(23);
`endif

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] inst, input imm_type_e kind);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (kind)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// IF->ID input bundle and ID->EX output bundle of the decode stage.
interface id_stage_if;
  import id_stage_pkg::*;

  logic               if2id_valid;
  logic [XLEN-1:0]    if2id_pc;
  logic [31:0]        if2id_instruction;

  logic               load_use_stall;

  logic               id2ex_valid;
  logic [XLEN-1:0]    id2ex_pc;
  logic [XLEN-1:0]    id2ex_rs1_data;
  logic [XLEN-1:0]    id2ex_rs2_data;
  logic [REG_AW-1:0]  id2ex_rs1_addr;
  logic [REG_AW-1:0]  id2ex_rs2_addr;
  logic [XLEN-1:0]    id2ex_imm;
  logic [REG_AW-1:0]  id2ex_rd_addr;
  logic               id2ex_rd_wen;
  logic [ALUOP_W-1:0] id2ex_alu_op;
  logic               id2ex_alu_src_imm;
  logic               id2ex_mem_read;
  logic               id2ex_mem_write;
  logic [2:0]         id2ex_mem_size;
  logic               id2ex_branch;
  logic               id2ex_jump;
  logic               id2ex_illegal;

  modport slave (
    input  if2id_valid, if2id_pc, if2id_instruction,
    output load_use_stall,
    output id2ex_valid, id2ex_pc, id2ex_rs1_data, id2ex_rs2_data,
           id2ex_rs1_addr, id2ex_rs2_addr, id2ex_imm, id2ex_rd_addr,
           id2ex_rd_wen, id2ex_alu_op, id2ex_alu_src_imm, id2ex_mem_read,
           id2ex_mem_write, id2ex_mem_size, id2ex_branch, id2ex_jump,
           id2ex_illegal
  );

  modport master (
    output if2id_valid, if2id_pc, if2id_instruction,
    input  load_use_stall,
    input  id2ex_valid, id2ex_pc, id2ex_rs1_data, id2ex_rs2_data,
           id2ex_rs1_addr, id2ex_rs2_addr, id2ex_imm, id2ex_rd_addr,
           id2ex_rd_wen, id2ex_alu_op, id2ex_alu_src_imm, id2ex_mem_read,
           id2ex_mem_write, id2ex_mem_size, id2ex_branch, id2ex_jump,
           id2ex_illegal
  );

endinterface

// File: rtl/id_stage_regfile.sv
// 32x32 integer register file: two combinational read ports with WB write-through, one write port.
module id_stage_regfile
  import id_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  input  logic              wen,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata
);

  // x0 has no storage; it reads as zero and absorbs writes
  logic [XLEN-1:0] regs [1:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (wen && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  function automatic logic [XLEN-1:0] rd_port(input logic [REG_AW-1:0] a);
    logic [XLEN-1:0] v;
    if (a == '0)                 v = '0;
    else if (wen && waddr == a)  v = wdata;
    else                         v = regs[a];
    return v;
  endfunction

  assign rs1_data = rd_port(rs1_addr);
  assign rs2_data = rd_port(rs2_addr);

endmodule

// File: rtl/id_stage.sv
// RV32I instruction decode stage: decode, register read, load-use hazard detect, ID/EX register.
// Build option VERIRISCV_RV32M_EN: decode the M-extension ops instead of flagging them illegal.
module id_stage
  import id_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_flush,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              wb_rd_wen,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]   wb_rd_data,
  id_stage_if.slave         bus
);

  logic [31:0]       inst;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [REG_AW-1:0] rs1, rs2, rd;

  assign inst   = bus.if2id_instruction;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  alu_op_t   d_alu_op;
  imm_type_e d_imm_type;
  logic      d_src_imm, d_rd_wen, d_mem_read, d_mem_write;
  logic      d_branch, d_jump, d_illegal, d_rs1_used, d_rs2_used;
  logic [XLEN-1:0] d_imm;
  logic [XLEN-1:0] rf_rs1_data, rf_rs2_data;
  logic      stall;

  always_comb begin
    d_alu_op    = ALU_ADD;
    d_imm_type  = IMM_NONE;
    d_src_imm   = 1'b0;
    d_rd_wen    = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_branch    = 1'b0;
    d_jump      = 1'b0;
    d_illegal   = 1'b0;
    d_rs1_used  = 1'b0;
    d_rs2_used  = 1'b0;

    case (opcode)
      OPC_LUI: begin
        d_imm_type = IMM_U;
        d_rd_wen   = 1'b1;
        d_src_imm  = 1'b1;
        d_alu_op   = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        d_imm_type = IMM_U;
        d_rd_wen   = 1'b1;
        d_src_imm  = 1'b1;
        d_alu_op   = ALU_ADD_PC;
      end
      OPC_JAL: begin
        d_imm_type = IMM_J;
        d_rd_wen   = 1'b1;
        d_jump     = 1'b1;
      end
      OPC_JALR: begin
        d_imm_type = IMM_I;
        d_rs1_used = 1'b1;
        d_rd_wen   = 1'b1;
        d_jump     = 1'b1;
        d_src_imm  = 1'b1;
        d_illegal  = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        d_imm_type = IMM_B;
        d_rs1_used = 1'b1;
        d_rs2_used = 1'b1;
        d_branch   = 1'b1;
        case (funct3)
          3'b000, 3'b001: d_alu_op = ALU_SUB;
          3'b100, 3'b101: d_alu_op = ALU_SLT;
          3'b110, 3'b111: d_alu_op = ALU_SLTU;
          default:        d_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d_imm_type = IMM_I;
        d_rs1_used = 1'b1;
        d_rd_wen   = 1'b1;
        d_mem_read = 1'b1;
        d_src_imm  = 1'b1;
        d_illegal  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        d_imm_type  = IMM_S;
        d_rs1_used  = 1'b1;
        d_rs2_used  = 1'b1;
        d_mem_write = 1'b1;
        d_src_imm   = 1'b1;
        d_illegal   = (funct3 > 3'b010);
      end
      OPC_OP_IMM: begin
        d_imm_type = IMM_I;
        d_rs1_used = 1'b1;
        d_rd_wen   = 1'b1;
        d_src_imm  = 1'b1;
        case (funct3)
          3'b000: d_alu_op = ALU_ADD;
          3'b010: d_alu_op = ALU_SLT;
          3'b011: d_alu_op = ALU_SLTU;
          3'b100: d_alu_op = ALU_XOR;
          3'b110: d_alu_op = ALU_OR;
          3'b111: d_alu_op = ALU_AND;
          3'b001: begin
            d_alu_op  = ALU_SLL;
            d_illegal = (funct7 != 7'b0000000);
          end
          default: begin
            if (funct7 == 7'b0000000)      d_alu_op = ALU_SRL;
            else if (funct7 == 7'b0100000) d_alu_op = ALU_SRA;
            else                           d_illegal = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        d_rs1_used = 1'b1;
        d_rs2_used = 1'b1;
        d_rd_wen   = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  d_alu_op = ALU_ADD;
            3'b001:  d_alu_op = ALU_SLL;
            3'b010:  d_alu_op = ALU_SLT;
            3'b011:  d_alu_op = ALU_SLTU;
            3'b100:  d_alu_op = ALU_XOR;
            3'b101:  d_alu_op = ALU_SRL;
            3'b110:  d_alu_op = ALU_OR;
            default: d_alu_op = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000)      d_alu_op = ALU_SUB;
          else if (funct3 == 3'b101) d_alu_op = ALU_SRA;
          else                       d_illegal = 1'b1;
`ifdef VERIRISCV_RV32M_EN
        end else if (funct7 == 7'b0000001) begin
          case (funct3)
            3'b000:  d_alu_op = ALU_MUL;
            3'b001:  d_alu_op = ALU_MULH;
            3'b010:  d_alu_op = ALU_MULHSU;
            3'b011:  d_alu_op = ALU_MULHU;
            3'b100:  d_alu_op = ALU_DIV;
            3'b101:  d_alu_op = ALU_DIVU;
            3'b110:  d_alu_op = ALU_REM;
            default: d_alu_op = ALU_REMU;
          endcase
`endif
        end else begin
          d_illegal = 1'b1;
        end
      end
      OPC_MISC_MEM: begin
        // FENCE is ordering-only in this in-order pipe: a legal no-op
      end
      OPC_SYSTEM: begin
        // only ECALL/EBREAK are legal; they carry no side-effect controls here
        d_illegal = (inst[31:21] != 11'b0) || (rs1 != '0) || (funct3 != 3'b000) || (rd != '0);
      end
      default: d_illegal = 1'b1;
    endcase

    if (d_illegal) begin
      d_alu_op    = ALU_ADD;
      d_imm_type  = IMM_NONE;
      d_src_imm   = 1'b0;
      d_rd_wen    = 1'b0;
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
      d_branch    = 1'b0;
      d_jump      = 1'b0;
      d_rs1_used  = 1'b0;
      d_rs2_used  = 1'b0;
    end
    if (rd == '0) d_rd_wen = 1'b0;
  end

  assign d_imm = imm_gen(inst, d_imm_type);

  assign stall = bus.if2id_valid && ex_mem_read && (ex_rd_addr != '0) &&
                 ((d_rs1_used && ex_rd_addr == rs1) || (d_rs2_used && ex_rd_addr == rs2));
  assign bus.load_use_stall = stall;

  id_stage_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rf_rs1_data),
    .rs2_data (rf_rs2_data),
    .wen      (wb_rd_wen),
    .waddr    (wb_rd_addr),
    .wdata    (wb_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.id2ex_valid       <= 1'b0;
      bus.id2ex_pc          <= '0;
      bus.id2ex_rs1_data    <= '0;
      bus.id2ex_rs2_data    <= '0;
      bus.id2ex_rs1_addr    <= '0;
      bus.id2ex_rs2_addr    <= '0;
      bus.id2ex_imm         <= '0;
      bus.id2ex_rd_addr     <= '0;
      bus.id2ex_rd_wen      <= 1'b0;
      bus.id2ex_alu_op      <= '0;
      bus.id2ex_alu_src_imm <= 1'b0;
      bus.id2ex_mem_read    <= 1'b0;
      bus.id2ex_mem_write   <= 1'b0;
      bus.id2ex_mem_size    <= '0;
      bus.id2ex_branch      <= 1'b0;
      bus.id2ex_jump        <= 1'b0;
      bus.id2ex_illegal     <= 1'b0;
    end else if (id_flush || stall) begin
      // bubble: data fields hold, only valid and side-effect controls drop
      bus.id2ex_valid     <= 1'b0;
      bus.id2ex_rd_wen    <= 1'b0;
      bus.id2ex_mem_read  <= 1'b0;
      bus.id2ex_mem_write <= 1'b0;
      bus.id2ex_branch    <= 1'b0;
      bus.id2ex_jump      <= 1'b0;
      bus.id2ex_illegal   <= 1'b0;
    end else begin
      bus.id2ex_valid       <= bus.if2id_valid;
      bus.id2ex_pc          <= bus.if2id_pc;
      bus.id2ex_rs1_data    <= rf_rs1_data;
      bus.id2ex_rs2_data    <= rf_rs2_data;
      bus.id2ex_rs1_addr    <= rs1;
      bus.id2ex_rs2_addr    <= rs2;
      bus.id2ex_imm         <= d_imm;
      bus.id2ex_rd_addr     <= rd;
      bus.id2ex_alu_op      <= d_alu_op;
      bus.id2ex_alu_src_imm <= d_src_imm;
      bus.id2ex_mem_size    <= funct3;
      bus.id2ex_rd_wen      <= d_rd_wen    && bus.if2id_valid;
      bus.id2ex_mem_read    <= d_mem_read  && bus.if2id_valid;
      bus.id2ex_mem_write   <= d_mem_write && bus.if2id_valid;
      bus.id2ex_branch      <= d_branch    && bus.if2id_valid;
      bus.id2ex_jump        <= d_jump      && bus.if2id_valid;
      bus.id2ex_illegal     <= d_illegal   && bus.if2id_valid;
    end
  end

endmodule
